// File: rtl/subtrator_serial_ctrl_if.sv
// Handshake/bus bundle for the bit-serial subtractor controller.
// Optional ovf signal present only when SUB_OVF_EN is defined.
interface subtrator_serial_ctrl_if #(
   parameter int N = 8
);
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         TE;
   logic         busy;
   logic         done;
   logic [N-1:0] R;
   logic         TS;
`ifdef SUB_OVF_EN
   logic         ovf;

   modport master (output start, A, B, TE, input busy, done, R, TS, ovf);
   modport slave  (input start, A, B, TE, output busy, done, R, TS, ovf);
`else
   modport master (output start, A, B, TE, input busy, done, R, TS);
   modport slave  (input start, A, B, TE, output busy, done, R, TS);
`endif
endinterface

// File: rtl/subtrator_serial_ctrl.sv
// Bit-serial N-bit subtractor controller: one full-subtractor cell is
// stepped across latched operands LSB first, one bit per clock.
// Handshake: start (sampled in IDLE) / busy (SHIFT) / done (1-cycle pulse).
// Optional feature macro: SUB_OVF_EN adds a signed-overflow flag (bus.ovf).
module subtrator_serial_ctrl #(
   parameter  int N  = 8,
   localparam int CW = $clog2(N+1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   subtrator_serial_ctrl_if.slave  bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [N-1:0]  ra_q, ra_d;      // minuend, shifted right each bit
   logic [N-1:0]  rb_q, rb_d;      // subtrahend, shifted right each bit
   logic [N-1:0]  rr_q, rr_d;      // result, assembled from the MSB down
   logic          bw_q, bw_d;      // running borrow
   logic [CW-1:0] cnt_q, cnt_d;    // bit index being processed
   logic [N-1:0]  r_q, r_d;        // published difference
   logic          ts_q, ts_d;      // published borrow-out
   logic          done_q, done_d;

   // Full-subtractor cell on the current LSBs.
   logic d_bit, bw_nxt;
   assign d_bit  = ra_q[0] ^ rb_q[0] ^ bw_q;
   assign bw_nxt = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & bw_q);

`ifdef SUB_OVF_EN
   // Operand MSBs are shifted out of ra/rb, so keep copies for the sign test.
   logic a_msb_q, a_msb_d;
   logic b_msb_q, b_msb_d;
   logic ovf_q, ovf_d;
`endif

   // Next-state logic: accept in IDLE, step one bit per SHIFT cycle, publish in DONE.
   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      rr_d    = rr_q;
      bw_d    = bw_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      ts_d    = ts_q;
      done_d  = 1'b0;
`ifdef SUB_OVF_EN
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      ovf_d   = ovf_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               ra_d    = bus.A;
               rb_d    = bus.B;
               bw_d    = bus.TE;
               rr_d    = '0;
               cnt_d   = '0;
               state_d = S_SHIFT;
`ifdef SUB_OVF_EN
               a_msb_d = bus.A[N-1];
               b_msb_d = bus.B[N-1];
`endif
            end
         end
         S_SHIFT: begin
            rr_d  = {d_bit, rr_q[N-1:1]};
            ra_d  = {1'b0, ra_q[N-1:1]};
            rb_d  = {1'b0, rb_q[N-1:1]};
            bw_d  = bw_nxt;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N-1)) state_d = S_DONE;
         end
         S_DONE: begin
            r_d     = rr_q;
            ts_d    = bw_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
`ifdef SUB_OVF_EN
            ovf_d   = (a_msb_q != b_msb_q) && (rr_q[N-1] != a_msb_q);
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         rr_q    <= '0;
         bw_q    <= 1'b0;
         cnt_q   <= '0;
         r_q     <= '0;
         ts_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         rr_q    <= rr_d;
         bw_q    <= bw_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         ts_q    <= ts_d;
         done_q  <= done_d;
      end
   end

`ifdef SUB_OVF_EN
   // Overflow flag and the latched operand signs it is derived from.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.ovf = ovf_q;
`endif

   assign bus.busy = (state_q == S_SHIFT);
   assign bus.done = done_q;
   assign bus.R    = r_q;
   assign bus.TS   = ts_q;

endmodule
